gba_capture_param: RTL and testbench

//  Parametrised video capture front-end between the handheld LCD bus and the line buffer.
//  - Synchronises dclk and vsync into the pixel clock domain.
//  - Samples RGB on dclk rising edges and expands IN_W-bit colour to OUT_W bits.
//  - Tracks pixel and line position, and flags malformed lines and frames.
//  - Adds an enable, a line counter and error detection (short, long, extra lines; mid-line vsync).

---
 rtl/capture_pkg.sv | 26 ++
 rtl/sync_edge_det.sv | 46 ++++
 rtl/gba_capture_param.sv | 180 ++++++++++++++++++
 tb/tb_gba_capture_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and helpers for the LCD capture front-end.
package capture_pkg;

  typedef enum logic [2:0] {IDLE, WAIT_LINE, IN_LINE, LINE_END, FRAME_DONE} capState_t;

  localparam int DEF_LINE_PXLS   = 240;
  localparam int DEF_FRAME_LINES = 160;
  localparam int PXL_CNT_W       = $clog2(DEF_LINE_PXLS);
  localparam int LINE_CNT_W      = $clog2(DEF_FRAME_LINES);
  localparam int COL_MAX_W       = 32;

  // Widen a colour by repeating its top bits into the new LSBs: {in, in[in_w-1 -: out_w-in_w]}.
  function automatic logic [COL_MAX_W-1:0] expandColour(input logic [COL_MAX_W-1:0] col,
                                                        input int in_w, input int out_w);
    logic [COL_MAX_W-1:0] res;
    res = '0;
    for (int i = 0; i < COL_MAX_W; i++) begin
      if (i < out_w) begin
        if (i >= out_w - in_w) res[i] = col[i - (out_w - in_w)];
        else                   res[i] = col[i + 2 * in_w - out_w];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser with registered rise/fall detection; q is delayed to stay aligned with the edge flags.
module sync_edge_det #(
  parameter int STGS = 2,
  parameter int W    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] stg_q [STGS];
  logic [W-1:0] stg_d [STGS];
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] rise_q, rise_d;
  logic [W-1:0] fall_q, fall_d;

  always_comb begin
    stg_d[0] = d;
    for (int i = 1; i < STGS; i++) stg_d[i] = stg_q[i-1];
    prev_d = stg_q[STGS-1];
    rise_d = stg_q[STGS-1] & ~prev_q;
    fall_d = ~stg_q[STGS-1] & prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STGS; i++) stg_q[i] <= '0;
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < STGS; i++) stg_q[i] <= stg_d[i];
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = prev_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/gba_capture_param.sv
// LCD bus capture: synchronises dot clock, vsync and colour, expands colour and tracks line/frame
// position with error flagging for short, long and extra lines and aborted frames.
module gba_capture_param
  import capture_pkg::*;
#(
  parameter int IN_W          = 5,
  parameter int OUT_W         = 8,
  parameter int LINE_PXLS     = DEF_LINE_PXLS,
  parameter int FRAME_LINES   = DEF_FRAME_LINES,
  parameter int SYNC_STGS     = 2,
  parameter int LINE_IDLE_CYC = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [IN_W-1:0]                redPxl,
  input  logic [IN_W-1:0]                greenPxl,
  input  logic [IN_W-1:0]                bluePxl,
  input  logic                           dclk,
  input  logic                           vsync,
  output logic [OUT_W-1:0]               redPxlOut,
  output logic [OUT_W-1:0]               greenPxlOut,
  output logic [OUT_W-1:0]               bluePxlOut,
  output logic                           validPxlOut,
  output logic [$clog2(LINE_PXLS)-1:0]   pxlCnt,
  output logic                           validLine,
  output logic [$clog2(FRAME_LINES)-1:0] lineCnt,
  output logic                           newFrame,
  output logic                           frameErr
);

  localparam int PW = $clog2(LINE_PXLS);
  localparam int LW = $clog2(FRAME_LINES);
  localparam int IW = $clog2(LINE_IDLE_CYC + 1);
  localparam logic [PW-1:0] PXL_LAST  = PW'(LINE_PXLS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_LINES - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(LINE_IDLE_CYC);
  localparam logic [IW-1:0] IDLE_LAST = IW'(LINE_IDLE_CYC - 1);

  logic dclk_rise, dclk_fall_unused, dclk_q_unused;
  logic vsync_fall, vsync_rise_unused, vsync_q_unused;
  logic [3*IN_W-1:0] col_sync, col_rise_unused, col_fall_unused;

  sync_edge_det #(.STGS(SYNC_STGS), .W(1)) u_dclk_sync (
    .clk(clk), .rst(rst), .d(dclk), .q(dclk_q_unused), .rise(dclk_rise), .fall(dclk_fall_unused));
  sync_edge_det #(.STGS(SYNC_STGS), .W(1)) u_vsync_sync (
    .clk(clk), .rst(rst), .d(vsync), .q(vsync_q_unused), .rise(vsync_rise_unused), .fall(vsync_fall));
  sync_edge_det #(.STGS(SYNC_STGS), .W(3*IN_W)) u_col_sync (
    .clk(clk), .rst(rst), .d({redPxl, greenPxl, bluePxl}), .q(col_sync),
    .rise(col_rise_unused), .fall(col_fall_unused));

  capState_t state_q, state_d;
  logic [PW-1:0] pxl_cnt_q, pxl_cnt_d, pxl_idx;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [OUT_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic valid_pxl_q, valid_pxl_d, valid_line_q, valid_line_d;
  logic new_frame_q, new_frame_d, frame_err_q, frame_err_d;
  logic emit;

  always_comb begin
    state_d      = state_q;
    pxl_cnt_d    = pxl_cnt_q;
    line_cnt_d   = line_cnt_q;
    frame_err_d  = frame_err_q;
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;
    valid_pxl_d  = 1'b0;
    valid_line_d = 1'b0;
    new_frame_d  = 1'b0;
    emit         = 1'b0;
    pxl_idx      = (state_q == IN_LINE) ? pxl_cnt_q + PW'(1) : '0;
    idle_cnt_d   = dclk_rise ? '0 : ((idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IW'(1));

    if (state_q != IDLE && vsync_fall && enable) begin
      new_frame_d = 1'b1;
      pxl_cnt_d   = '0;
      line_cnt_d  = '0;
      frame_err_d = (pxl_cnt_q != '0) || (line_cnt_q != LINE_LAST);
      idle_cnt_d  = IDLE_MAX;
      state_d     = WAIT_LINE;
    end else begin
      case (state_q)
        IDLE: begin
          if (vsync_fall && enable) begin
            new_frame_d = 1'b1;
            pxl_cnt_d   = '0;
            line_cnt_d  = '0;
            frame_err_d = 1'b0;
            idle_cnt_d  = IDLE_MAX;
            state_d     = WAIT_LINE;
          end
        end
        WAIT_LINE: begin
          // An edge before the line gap has elapsed is a surplus pixel of the previous line.
          if (dclk_rise) begin
            if (idle_cnt_q != IDLE_MAX) frame_err_d = 1'b1;
            else                        emit = 1'b1;
          end
        end
        IN_LINE: begin
          if (dclk_rise) begin
            emit = 1'b1;
          end else if (idle_cnt_q == IDLE_LAST) begin
            pxl_cnt_d   = '0;
            frame_err_d = 1'b1;
            state_d     = WAIT_LINE;
          end
        end
        LINE_END: begin
          valid_line_d = 1'b1;
          pxl_cnt_d    = '0;
          if (dclk_rise) frame_err_d = 1'b1;
          if (line_cnt_q == LINE_LAST) begin
            state_d = FRAME_DONE;
          end else begin
            line_cnt_d = line_cnt_q + LW'(1);
            state_d    = WAIT_LINE;
          end
        end
        FRAME_DONE: begin
          if (dclk_rise) frame_err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (emit) begin
      valid_pxl_d = 1'b1;
      pxl_cnt_d   = pxl_idx;
      red_d   = OUT_W'(expandColour(COL_MAX_W'(col_sync[3*IN_W-1 -: IN_W]), IN_W, OUT_W));
      green_d = OUT_W'(expandColour(COL_MAX_W'(col_sync[2*IN_W-1 -: IN_W]), IN_W, OUT_W));
      blue_d  = OUT_W'(expandColour(COL_MAX_W'(col_sync[IN_W-1:0]), IN_W, OUT_W));
      state_d = (pxl_idx == PXL_LAST) ? LINE_END : IN_LINE;
    end

    // Disabling lets an active line run to completion before parking in IDLE.
    if (!enable && (state_d == WAIT_LINE || state_d == FRAME_DONE)) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pxl_cnt_q    <= '0;
      line_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      valid_pxl_q  <= 1'b0;
      valid_line_q <= 1'b0;
      new_frame_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pxl_cnt_q    <= pxl_cnt_d;
      line_cnt_q   <= line_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      valid_pxl_q  <= valid_pxl_d;
      valid_line_q <= valid_line_d;
      new_frame_q  <= new_frame_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign redPxlOut   = red_q;
  assign greenPxlOut = green_q;
  assign bluePxlOut  = blue_q;
  assign validPxlOut = valid_pxl_q;
  assign pxlCnt      = pxl_cnt_q;
  assign validLine   = valid_line_q;
  assign lineCnt     = line_cnt_q;
  assign newFrame    = new_frame_q;
  assign frameErr    = frame_err_q;

endmodule

// File: tb/tb_gba_capture_param.sv
// Directed/randomised bench for gba_capture_param with a frame-level reference model and pixel scoreboard.
module tb_gba_capture_param;

  localparam int IN_W = 5, OUT_W = 8, LP = 12, FL = 5, SS = 3, IDLE_C = 16;
  localparam int GAP = IDLE_C + 10;
  localparam int PW = $clog2(LP), LW = $clog2(FL);

  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, dclk = 1'b0, vsync = 1'b1;
  logic [IN_W-1:0] red = '0, green = '0, blue = '0;
  logic [OUT_W-1:0] red_o, green_o, blue_o;
  logic valid_o, vline_o, nf_o, err_o;
  logic [PW-1:0] pxl_cnt_o;
  logic [LW-1:0] line_cnt_o;

  always #5 clk = ~clk;

  gba_capture_param #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LINE_PXLS(LP), .FRAME_LINES(FL),
    .SYNC_STGS(SS), .LINE_IDLE_CYC(IDLE_C)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .redPxl(red), .greenPxl(green), .bluePxl(blue),
    .dclk(dclk), .vsync(vsync),
    .redPxlOut(red_o), .greenPxlOut(green_o), .bluePxlOut(blue_o),
    .validPxlOut(valid_o), .pxlCnt(pxl_cnt_o), .validLine(vline_o),
    .lineCnt(line_cnt_o), .newFrame(nf_o), .frameErr(err_o)
  );

  typedef struct {int idx; logic [23:0] rgb;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_cmp = 0, n_bad = 0;
  int o_px = 0, o_vl = 0, o_nf = 0;
  int m_px = 0, m_vl = 0, m_nf = 0, m_lines = 0, m_linecnt = 0;
  bit m_active = 1'b0, m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ref_expand(input logic [IN_W-1:0] x);
    int v;
    v = int'(x);
    return 8'((v << (OUT_W - IN_W)) | (v >> (2 * IN_W - OUT_W)));
  endfunction

  // Scoreboard: every emitted pixel must match the next expected one.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cnt_range", {63'd0, (pxl_cnt_o <= PW'(LP - 1)) && (line_cnt_o <= LW'(FL - 1))}, 64'd1);
      if (valid_o) begin
        o_px++;
        if (exp_q.size() == 0) chk("stray_pixel", exp_q.size(), 1);
        else begin
          mon_e = exp_q.pop_front();
          chk("pxl_idx", pxl_cnt_o, mon_e.idx);
          chk("pxl_rgb", {red_o, green_o, blue_o}, mon_e.rgb);
        end
      end
      if (vline_o) o_vl++;
      if (nf_o) o_nf++;
    end
  end

  task automatic check_state(input string tag);
    chk({tag, "/frameErr"}, err_o, m_err);
    chk({tag, "/lineCnt"}, line_cnt_o, m_linecnt);
    chk({tag, "/pxlCnt"}, pxl_cnt_o, 0);
    chk({tag, "/validLines"}, o_vl, m_vl);
    chk({tag, "/newFrames"}, o_nf, m_nf);
    chk({tag, "/pixels"}, o_px, m_px);
    chk({tag, "/pending"}, exp_q.size(), 0);
  endtask

  task automatic model_px(input int idx, input logic [IN_W-1:0] r, g, b);
    if (m_active && m_lines < FL && idx < LP) begin
      exp_q.push_back('{idx, {ref_expand(r), ref_expand(g), ref_expand(b)}});
      m_px++;
    end
  endtask

  task automatic send_px(input logic [IN_W-1:0] r, g, b);
    @(negedge clk); dclk = 1'b1; red = r; green = g; blue = b;
    @(negedge clk);
    @(negedge clk); dclk = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_line(input int first, input int n, input bit fixed,
                           input logic [IN_W-1:0] c, input string name);
    logic [IN_W-1:0] r, g, b;
    int tot;
    for (int i = 0; i < n; i++) begin
      r = fixed ? c : IN_W'($urandom);
      g = fixed ? c : IN_W'($urandom);
      b = fixed ? c : IN_W'($urandom);
      model_px(first + i, r, g, b);
      send_px(r, g, b);
    end
    repeat (GAP) @(negedge clk);
    tot = first + n;
    if (m_active) begin
      if (m_lines >= FL) begin
        if (tot > 0) m_err = 1'b1;
      end else if (tot < LP) begin
        m_err = 1'b1;
      end else begin
        if (tot > LP) m_err = 1'b1;
        m_lines++;
        m_vl++;
        m_linecnt = (m_lines < FL - 1) ? m_lines : FL - 1;
      end
    end
    $display("line %s: %0d px, lines in frame %0d", name, tot, m_lines);
    check_state(name);
  endtask

  task automatic vfall(input string name);
    @(negedge clk); vsync = 1'b0;
    repeat (8) @(negedge clk);
    vsync = 1'b1;
    repeat (8) @(negedge clk);
    if (enable) begin
      m_err = m_active && (m_lines < FL);
      m_active = 1'b1;
      m_lines = 0;
      m_linecnt = 0;
      m_nf++;
    end
    $display("vsync %s: enable=%0b newFrames %0d", name, enable, m_nf);
    check_state(name);
  endtask

  initial begin
    logic [IN_W-1:0] r, g, b;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {red_o, green_o, blue_o, valid_o, pxl_cnt_o, vline_o, line_cnt_o, nf_o, err_o}, 0);
    rst = 1'b0;
    $display("reset released");

    // Reset in the middle of a line, then a line with no vsync must be ignored.
    vfall("frame_a");
    for (int i = 0; i < 5; i++) begin
      r = IN_W'($urandom); g = IN_W'($urandom); b = IN_W'($urandom);
      model_px(i, r, g, b);
      send_px(r, g, b);
    end
    repeat (8) @(negedge clk);
    chk("pre_reset_pending", exp_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midline_reset_outputs", {red_o, green_o, blue_o, valid_o, pxl_cnt_o, vline_o, line_cnt_o, nf_o, err_o}, 0);
    rst = 1'b0;
    m_active = 1'b0; m_err = 1'b0; m_lines = 0; m_linecnt = 0;
    $display("midline reset applied");
    send_line(0, LP, 1'b0, '0, "no_vsync");

    // Complete clean frame of mid-grey pixels.
    vfall("frame_b");
    for (int l = 0; l < FL; l++) send_line(0, LP, 1'b1, IN_W'(16), "frame_b");

    // Short line then a full one; then a long line.
    vfall("frame_c");
    send_line(0, LP - 1, 1'b0, '0, "short");
    send_line(0, LP, 1'b0, '0, "after_short");
    send_line(0, LP + 1, 1'b0, '0, "long");

    // Frame aborted mid-line, followed by a clean frame that clears the error.
    vfall("frame_d");
    send_line(0, LP, 1'b0, '0, "frame_d");
    send_line(0, LP, 1'b0, '0, "frame_d");
    for (int i = 0; i < 6; i++) begin
      r = IN_W'($urandom); g = IN_W'($urandom); b = IN_W'($urandom);
      model_px(i, r, g, b);
      send_px(r, g, b);
    end
    repeat (8) @(negedge clk);
    vfall("abort");
    for (int l = 0; l < FL; l++) send_line(0, LP, 1'b0, '0, "clean");
    vfall("clean_end");

    // Latency: dclk first sampled high at edge N, pixel strobe only at edge N+SS+1.
    r = IN_W'($urandom); g = IN_W'($urandom); b = IN_W'($urandom);
    model_px(0, r, g, b);
    @(negedge clk); dclk = 1'b1; red = r; green = g; blue = b;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("latency_edge_%0d", k), valid_o, (k == SS + 1));
      if (k == 2) dclk = 1'b0;
    end
    $display("latency pixel checked");
    send_line(1, LP - 1, 1'b0, '0, "latency_rest");

    // Disabled: vsync must not start a frame and pixels are ignored.
    enable = 1'b0;
    m_active = 1'b0;
    repeat (4) @(negedge clk);
    vfall("disabled");
    send_line(0, LP, 1'b0, '0, "disabled_line");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
